hdpldadapt_cmn_pulse_stretch_bank: RTL and testbench



---
 rtl/hdpldadapt_cmn_pulse_stretch_bank.sv | 73 +++++++
 tb/tb_hdpldadapt_cmn_pulse_stretch_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdpldadapt_cmn_pulse_stretch_bank.sv
`default_nettype none
// ============================================================================
//  Module   : hdpldadapt_cmn_pulse_stretch_bank
//  Purpose  : Multi-channel counter-based pulse stretcher. Each channel holds
//             its active level for r_stretch_len extra cycles after its input
//             returns to the idle level given by RESET_VAL.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             data_in           - raw per-channel signals
//             r_stretch_len     - extension length, shared, sampled on load
//             r_stretch_en      - per-channel enable (0 = registered copy)
//             data_out          - stretched outputs (registered)
//             stretch_busy      - per-channel countdown in progress
//             any_active        - some output differs from its idle level
//  Revision : 1.0 - initial release
// ============================================================================
module hdpldadapt_cmn_pulse_stretch_bank #(
    parameter int                       NUM_CH    = 5,
    parameter int                       CNT_W     = 4,
    parameter logic [NUM_CH-1:0]        RESET_VAL = 5'b11000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   data_in,
    input  logic [CNT_W-1:0]    r_stretch_len,
    input  logic [NUM_CH-1:0]   r_stretch_en,
    output logic [NUM_CH-1:0]   data_out,
    output logic [NUM_CH-1:0]   stretch_busy,
    output logic                any_active
);

    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
            logic             r_out;
            logic [CNT_W-1:0] r_cnt;
            logic             w_act;

            // A channel is active whenever its input departs from its idle level.
            assign w_act = data_in[gi] ^ RESET_VAL[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out <= RESET_VAL[gi];
                    r_cnt <= C_CNT_ZERO;
                end else if (!r_stretch_en[gi]) begin
                    r_out <= data_in[gi];
                    r_cnt <= C_CNT_ZERO;
                end else if (w_act) begin
                    // Load (or reload on retrigger) from the current length.
                    r_out <= ~RESET_VAL[gi];
                    r_cnt <= r_stretch_len;
                end else if (r_cnt != C_CNT_ZERO) begin
                    // Only decrements while non-zero, so it can never wrap.
                    r_out <= ~RESET_VAL[gi];
                    r_cnt <= r_cnt - C_CNT_ONE;
                end else begin
                    r_out <= RESET_VAL[gi];
                end
            end

            assign data_out[gi]     = r_out;
            assign stretch_busy[gi] = (r_cnt != C_CNT_ZERO);
        end
    endgenerate

    // Decoded purely from the output registers; no input-to-output path.
    assign any_active = |(data_out ^ RESET_VAL);

endmodule
`default_nettype wire

// File: tb/tb_hdpldadapt_cmn_pulse_stretch_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hdpldadapt_cmn_pulse_stretch_bank
//  Purpose  : Self-checking bench for the pulse stretch bank. A behavioural
//             model predicts each clock edge's outputs into a queue; each
//             scenario task pops and compares after the edge, and also checks
//             scenario-level pulse widths against fixed expected numbers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hdpldadapt_cmn_pulse_stretch_bank;

    localparam int          NCH = 5;
    localparam logic [4:0]  RV  = 5'b11000;
    localparam logic [4:0]  ALL = 5'b11111;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] data_in;
    logic [3:0] r_stretch_len;
    logic [4:0] r_stretch_en;
    logic [4:0] data_out;
    logic [4:0] stretch_busy;
    logic       any_active;

    int total = 0;
    int bad   = 0;

    logic [10:0] sb[$];
    logic [10:0] exp_v;
    logic [4:0]  m_out;
    logic [3:0]  m_cnt [NCH];

    hdpldadapt_cmn_pulse_stretch_bank dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .r_stretch_len (r_stretch_len),
        .r_stretch_en  (r_stretch_en),
        .data_out      (data_out),
        .stretch_busy  (stretch_busy),
        .any_active    (any_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, predict the post-edge outputs into the
    // scoreboard, then advance to 1 ns after the rising edge.
    task automatic tick(input logic r, input logic [4:0] d,
                        input logic [3:0] len, input logic [4:0] en);
        logic [4:0] eb;
        rst = r; data_in = d; r_stretch_len = len; r_stretch_en = en;
        for (int i = 0; i < NCH; i++) begin
            if (r) begin
                m_out[i] = RV[i]; m_cnt[i] = 4'd0;
            end else if (!en[i]) begin
                m_out[i] = d[i]; m_cnt[i] = 4'd0;
            end else if (d[i] != RV[i]) begin
                m_out[i] = ~RV[i]; m_cnt[i] = len;
            end else if (m_cnt[i] != 4'd0) begin
                m_out[i] = ~RV[i]; m_cnt[i] = m_cnt[i] - 4'd1;
            end else begin
                m_out[i] = RV[i];
            end
            eb[i] = (m_cnt[i] != 4'd0);
        end
        sb.push_back({m_out, eb, |(m_out ^ RV)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 5'b00111, 4'd0, ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL reset_sb: got %b want %b", {data_out, stretch_busy, any_active}, exp_v);
            end
            total++;
            if (data_out !== RV || stretch_busy !== 5'b0 || any_active !== 1'b0) begin
                bad++;
                $display("FAIL reset_state: got out=%b busy=%b any=%b want out=%b busy=00000 any=0",
                         data_out, stretch_busy, any_active, RV);
            end
        end
        tick(1'b0, 5'b00111, 4'd0, ALL);
        exp_v = sb.pop_front(); total++;
        if ({data_out, stretch_busy, any_active} !== exp_v) begin
            bad++;
            $display("FAIL reset_release_sb: got %b want %b", {data_out, stretch_busy, any_active}, exp_v);
        end
        total++;
        if (data_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ch0: got %b want 1", data_out[0]);
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, RV, 4'd0, ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL reset_drain_sb: got %b want %b", {data_out, stretch_busy, any_active}, exp_v);
            end
        end
    endtask

    task automatic test_basic_stretch();
        int hi = 0, bz = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, (k == 2) ? 5'b11001 : RV, 4'd3, ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL basic_sb cyc%0d: got %b want %b", k, {data_out, stretch_busy, any_active}, exp_v);
            end
            if (data_out[0]) hi++;
            if (stretch_busy[0]) bz++;
        end
        total++;
        if (hi != 4) begin
            bad++; $display("FAIL basic_width: got %0d cycles want 4", hi);
        end
        total++;
        if (bz != 3) begin
            bad++; $display("FAIL basic_busy: got %0d cycles want 3", bz);
        end
    endtask

    task automatic test_inverted_idle();
        int lo = 0, an = 0;
        for (int k = 0; k < 9; k++) begin
            tick(1'b0, (k == 1 || k == 2) ? 5'b01000 : RV, 4'd2, ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL inv_sb cyc%0d: got %b want %b", k, {data_out, stretch_busy, any_active}, exp_v);
            end
            if (!data_out[4]) lo++;
            if (any_active) an++;
        end
        total++;
        if (lo != 4) begin
            bad++; $display("FAIL inv_width: got %0d cycles want 4", lo);
        end
        total++;
        if (an != 4) begin
            bad++; $display("FAIL inv_any: got %0d cycles want 4", an);
        end
    endtask

    task automatic test_retrigger();
        logic [3:0] len;
        for (int k = 0; k < 10; k++) begin
            len = (k < 2) ? 4'd5 : 4'd1;
            tick(1'b0, (k == 0 || k == 3) ? 5'b11010 : RV, len, ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL retrig_sb cyc%0d: got %b want %b", k, {data_out, stretch_busy, any_active}, exp_v);
            end
            total++;
            if (data_out[1] !== (k <= 4)) begin
                bad++;
                $display("FAIL retrig_ch1 cyc%0d: got %b want %b", k, data_out[1], (k <= 4));
            end
        end
    endtask

    task automatic test_bypass_abort();
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, (k == 0 || k >= 4) ? 5'b11100 : RV, 4'd7,
                 (k >= 2) ? 5'b11011 : ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL bypass_sb cyc%0d: got %b want %b", k, {data_out, stretch_busy, any_active}, exp_v);
            end
            if (k == 1) begin
                total++;
                if (data_out[2] !== 1'b1 || stretch_busy[2] !== 1'b1) begin
                    bad++;
                    $display("FAIL bypass_pre: got out=%b busy=%b want 1 1", data_out[2], stretch_busy[2]);
                end
            end
            if (k >= 2) begin
                total++;
                if (data_out[2] !== data_in[2] || stretch_busy[2] !== 1'b0) begin
                    bad++;
                    $display("FAIL bypass_follow cyc%0d: got out=%b busy=%b want %b 0",
                             k, data_out[2], stretch_busy[2], data_in[2]);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, RV, 4'd0, ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL bypass_drain_sb: got %b want %b", {data_out, stretch_busy, any_active}, exp_v);
            end
        end
    endtask

    task automatic test_boundary();
        int hi = 0, bz = 0;
        logic [4:0] d;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, (k == 0) ? 5'b11001 : RV, 4'd15, ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL max_sb cyc%0d: got %b want %b", k, {data_out, stretch_busy, any_active}, exp_v);
            end
            if (data_out[0]) hi++;
            if (stretch_busy[0]) bz++;
        end
        total++;
        if (hi != 16) begin
            bad++; $display("FAIL max_width: got %0d cycles want 16", hi);
        end
        total++;
        if (bz != 15) begin
            bad++; $display("FAIL max_busy: got %0d cycles want 15", bz);
        end
        for (int k = 0; k < 200; k++) begin
            d = 5'($urandom);
            tick(1'b0, d, 4'd0, ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL len0_sb cyc%0d: got %b want %b", k, {data_out, stretch_busy, any_active}, exp_v);
            end
            total++;
            if (data_out !== d || stretch_busy !== 5'b0) begin
                bad++;
                $display("FAIL len0_copy cyc%0d: got out=%b busy=%b want out=%b busy=00000",
                         k, data_out, stretch_busy, d);
            end
        end
    endtask

    task automatic test_reset_mid_stretch();
        for (int k = 0; k < 4; k++) begin
            tick(k == 2, (k == 0) ? 5'b11001 : RV, 4'd9, ALL);
            exp_v = sb.pop_front(); total++;
            if ({data_out, stretch_busy, any_active} !== exp_v) begin
                bad++;
                $display("FAIL midrst_sb cyc%0d: got %b want %b", k, {data_out, stretch_busy, any_active}, exp_v);
            end
            if (k >= 2) begin
                total++;
                if (data_out !== RV || stretch_busy !== 5'b0) begin
                    bad++;
                    $display("FAIL midrst_idle cyc%0d: got out=%b busy=%b want %b 00000",
                             k, data_out, stretch_busy, RV);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; data_in = RV; r_stretch_len = 4'd0; r_stretch_en = ALL;
        m_out = RV;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 4'd0;
        test_reset();
        test_basic_stretch();
        test_inverted_idle();
        test_retrigger();
        test_bypass_abort();
        test_boundary();
        test_reset_mid_stretch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
